// File: rtl/tl_store_buffer_ctrl.sv
// Store buffer for the TL stage: queues word stores, drains them to the data-cache
// write port when loads allow, and forwards the youngest matching store to TL loads.
module tl_store_buffer_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        tl_valid_i,
    input  logic        tl_is_store_i,
    input  logic        tl_is_load_i,
    input  logic [31:0] tl_cache_addr_i,
    input  logic [31:0] tl_store_data_i,
    output logic        sb_stall_o,
    output logic        ld_fwd_hit_o,
    output logic [31:0] ld_fwd_data_o,
    output logic        cache_wr_req_o,
    output logic [31:0] cache_wr_addr_o,
    output logic [31:0] cache_wr_data_o,
    input  logic        cache_wr_gnt_i,
    output logic        sb_empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } sb_entry_t;

    sb_entry_t              mem_q [DEPTH];
    logic [PTR_W-1:0]       head_q;
    logic [PTR_W-1:0]       tail_q;
    logic [CNT_W-1:0]       count_q;

    logic                   full_c;
    logic                   empty_c;
    logic                   tl_store_c;
    logic                   tl_load_c;
    logic                   push_c;
    logic                   pop_c;
    logic [PTR_W-1:0]       fwd_idx_c;
    logic [1:0]             addr_lsb_unused;

    assign addr_lsb_unused = tl_cache_addr_i[1:0];

    assign full_c     = (count_q == CNT_W'(DEPTH));
    assign empty_c    = (count_q == '0);
    assign tl_store_c = tl_valid_i & tl_is_store_i;
    assign tl_load_c  = tl_valid_i & tl_is_load_i;

    // A full buffer wins over loads so stores cannot starve behind load traffic.
    assign cache_wr_req_o  = ~empty_c & (~tl_load_c | full_c);
    assign cache_wr_addr_o = {mem_q[head_q].addr, 2'b00};
    assign cache_wr_data_o = mem_q[head_q].data;

    assign push_c     = tl_store_c & ~full_c;
    assign pop_c      = cache_wr_req_o & cache_wr_gnt_i;
    assign sb_stall_o = tl_store_c & full_c;
    assign sb_empty_o = empty_c;

    // Scan oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        ld_fwd_hit_o  = 1'b0;
        ld_fwd_data_o = '0;
        fwd_idx_c     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx_c = head_q + PTR_W'(i);
            if (tl_load_c && (CNT_W'(i) < count_q) &&
                (mem_q[fwd_idx_c].addr == tl_cache_addr_i[31:2])) begin
                ld_fwd_hit_o  = 1'b1;
                ld_fwd_data_o = mem_q[fwd_idx_c].data;
            end
        end
    end

    // Storage is cleared on reset so the write-port outputs read zero out of reset.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_c) begin
                mem_q[tail_q] <= '{addr: tl_cache_addr_i[31:2], data: tl_store_data_i};
                tail_q        <= tail_q + PTR_W'(1);
            end
            if (pop_c) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_store_buffer_ctrl.sv
// Self-checking bench for tl_store_buffer_ctrl against a queue-based store buffer model.
module tb_tl_store_buffer_ctrl;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rsn;
    logic        tl_valid;
    logic        tl_is_store;
    logic        tl_is_load;
    logic [31:0] tl_addr;
    logic [31:0] tl_data;
    logic        sb_stall;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_gnt;
    logic        sb_empty;

    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
    } ent_t;

    typedef struct packed {
        logic        stall;
        logic        hit;
        logic [31:0] fdata;
        logic        req;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        empty;
    } obs_t;

    ent_t q[$];
    ent_t issued[$];
    ent_t written[$];
    int   n_checks;
    int   n_pass;
    obs_t ob;
    obs_t ex;

    tl_store_buffer_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rsn_i          (rsn),
        .tl_valid_i     (tl_valid),
        .tl_is_store_i  (tl_is_store),
        .tl_is_load_i   (tl_is_load),
        .tl_cache_addr_i(tl_addr),
        .tl_store_data_i(tl_data),
        .sb_stall_o     (sb_stall),
        .ld_fwd_hit_o   (fwd_hit),
        .ld_fwd_data_o  (fwd_data),
        .cache_wr_req_o (wr_req),
        .cache_wr_addr_o(wr_addr),
        .cache_wr_data_o(wr_data),
        .cache_wr_gnt_i (wr_gnt),
        .sb_empty_o     (sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: FIFO of pending stores; outputs follow the arbitration rules directly.
    function automatic obs_t expected();
        obs_t e;
        bit   found;
        bit   ld;
        e     = '0;
        found = 1'b0;
        ld    = tl_valid && tl_is_load;
        e.empty = (q.size() == 0);
        e.stall = tl_valid && tl_is_store && (q.size() == DEPTH);
        e.req   = (q.size() != 0) && (!ld || (q.size() == DEPTH));
        if (e.req) begin
            e.waddr = {q[0].a, 2'b00};
            e.wdata = q[0].d;
        end
        if (ld) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!found && q[i].a == tl_addr[31:2]) begin
                    found   = 1'b1;
                    e.hit   = 1'b1;
                    e.fdata = q[i].d;
                end
            end
        end
        return e;
    endfunction

    function automatic obs_t observed();
        obs_t o;
        o       = '0;
        o.stall = sb_stall;
        o.hit   = fwd_hit;
        o.fdata = fwd_data;
        o.req   = wr_req;
        o.empty = sb_empty;
        if (wr_req) begin
            o.waddr = wr_addr;
            o.wdata = wr_data;
        end
        return o;
    endfunction

    task automatic tick();
        bit   push;
        bit   pop;
        obs_t e;
        e    = expected();
        push = rsn && tl_valid && tl_is_store && (q.size() < DEPTH);
        pop  = rsn && e.req && wr_gnt;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(ent_t'({tl_addr[31:2], tl_data}));
        #1;
    endtask

    task automatic drive_idle();
        tl_valid    = 1'b0;
        tl_is_store = 1'b0;
        tl_is_load  = 1'b0;
        tl_addr     = '0;
        tl_data     = '0;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d);
        tl_valid    = 1'b1;
        tl_is_store = 1'b1;
        tl_is_load  = 1'b0;
        tl_addr     = a;
        tl_data     = d;
    endtask

    task automatic drive_load(input logic [31:0] a);
        tl_valid    = 1'b1;
        tl_is_store = 1'b0;
        tl_is_load  = 1'b1;
        tl_addr     = a;
        tl_data     = '0;
    endtask

    task automatic drain();
        drive_idle();
        wr_gnt = 1'b1;
        for (int c = 0; c < 2 * DEPTH; c++) begin
            @(negedge clk);
            ob = observed(); ex = expected(); n_checks++;
            if (ob !== ex) $display("FAIL drain c%0d got %h exp %h", c, ob, ex);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset();
        rsn    = 1'b0;
        wr_gnt = 1'b0;
        drive_idle();
        #12;
        n_checks++;
        if ({sb_stall, fwd_hit, fwd_data, wr_req, wr_addr, wr_data, sb_empty} !== {1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1})
            $display("FAIL reset_init got %b/%b/%h/%b/%h/%h/%b exp all 0, empty 1",
                     sb_stall, fwd_hit, fwd_data, wr_req, wr_addr, wr_data, sb_empty);
        else n_pass++;
        @(posedge clk); #1;
        rsn = 1'b1;
        // queue two stores then reset asynchronously while a load would forward
        drive_store(32'h0000_0A00, 32'hAAAA_0001); tick();
        drive_store(32'h0000_0A04, 32'hAAAA_0002); tick();
        drive_load(32'h0000_0A04);
        wr_gnt = 1'b1;
        #2;
        n_checks++;
        if (fwd_hit !== 1'b1) $display("FAIL reset_prehit got %b exp 1", fwd_hit);
        else n_pass++;
        rsn = 1'b0;
        #1;
        q.delete();
        ob = observed(); ex = expected(); n_checks++;
        if (ob !== ex) $display("FAIL reset_async got %h exp %h", ob, ex);
        else n_pass++;
        n_checks++;
        if ({wr_addr, wr_data} !== 64'h0) $display("FAIL reset_wrport got %h_%h exp 0_0", wr_addr, wr_data);
        else n_pass++;
        @(posedge clk); #1;
        rsn = 1'b1;
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (sb_empty !== 1'b1 || wr_req !== 1'b0)
                $display("FAIL reset_after c%0d got empty %b req %b exp empty 1 req 0", c, sb_empty, wr_req);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_single_store();
        wr_gnt = 1'b1;
        drive_store(32'h0000_0100, 32'hDEAD_BEEF);
        @(negedge clk);
        n_checks++;
        if (wr_req !== 1'b0 || sb_empty !== 1'b1)
            $display("FAIL single_n got req %b empty %b exp req 0 empty 1", wr_req, sb_empty);
        else n_pass++;
        tick();
        drive_idle();
        @(negedge clk);
        n_checks++;
        if ({wr_req, wr_addr, wr_data, sb_empty} !== {1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0})
            $display("FAIL single_n1 got req %b addr %h data %h empty %b exp 1 00000100 deadbeef 0",
                     wr_req, wr_addr, wr_data, sb_empty);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (sb_empty !== 1'b1 || wr_req !== 1'b0)
            $display("FAIL single_n2 got empty %b req %b exp empty 1 req 0", sb_empty, wr_req);
        else n_pass++;
    endtask

    task automatic test_forward();
        wr_gnt = 1'b0;
        drive_store(32'h200, 32'h11); tick();
        drive_store(32'h204, 32'h22); tick();
        drive_store(32'h200, 32'h33); tick();
        drive_load(32'h202);
        @(negedge clk);
        n_checks++;
        if (fwd_hit !== 1'b1 || fwd_data !== 32'h33)
            $display("FAIL fwd_youngest got hit %b data %h exp 1 00000033", fwd_hit, fwd_data);
        else n_pass++;
        tick();
        drive_load(32'h208);
        @(negedge clk);
        n_checks++;
        if (fwd_hit !== 1'b0 || fwd_data !== 32'h0)
            $display("FAIL fwd_miss got hit %b data %h exp 0 00000000", fwd_hit, fwd_data);
        else n_pass++;
        tick();
        // entry popped this cycle must still forward
        drive_load(32'h204);
        wr_gnt = 1'b1;
        drive_store(32'h20C, 32'h44); tick();
        drive_load(32'h200);
        @(negedge clk);
        ob = observed(); ex = expected(); n_checks++;
        if (ob !== ex) $display("FAIL fwd_full_load got %h exp %h", ob, ex);
        else n_pass++;
        tick();
        drain();
    endtask

    task automatic test_load_priority();
        wr_gnt = 1'b0;
        drive_store(32'h400, 32'hB0); tick();
        drive_store(32'h404, 32'hB1); tick();
        wr_gnt = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive_load(32'h404 + 32'(c));
            @(negedge clk);
            n_checks++;
            if (wr_req !== 1'b0) $display("FAIL ld_prio c%0d got req %b exp 0", c, wr_req);
            else n_pass++;
            tick();
        end
        wr_gnt = 1'b0;
        drive_store(32'h408, 32'hB2); tick();
        drive_store(32'h40C, 32'hB3); tick();
        drive_load(32'h40C);
        @(negedge clk);
        n_checks++;
        if (wr_req !== 1'b1 || wr_addr !== 32'h400 || fwd_data !== 32'hB3)
            $display("FAIL ld_full_override got req %b addr %h fwd %h exp 1 00000400 000000b3",
                     wr_req, wr_addr, fwd_data);
        else n_pass++;
        wr_gnt = 1'b1;
        tick();
        @(negedge clk);
        ob = observed(); ex = expected(); n_checks++;
        if (ob !== ex) $display("FAIL ld_after_pop got %h exp %h", ob, ex);
        else n_pass++;
        tick();
        drain();
    endtask

    task automatic test_full_stall();
        wr_gnt = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            drive_store(32'h500 + 32'(4 * k), 32'hC0 + 32'(k));
            tick();
        end
        drive_store(32'h5F0, 32'hC_FFFF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (sb_stall !== 1'b1 || wr_req !== 1'b1)
                $display("FAIL stall_hold c%0d got stall %b req %b exp 1 1", c, sb_stall, wr_req);
            else n_pass++;
            tick();
        end
        wr_gnt = 1'b1;
        @(negedge clk);
        n_checks++;
        if (sb_stall !== 1'b1) $display("FAIL stall_pop_cycle got %b exp 1", sb_stall);
        else n_pass++;
        tick();
        wr_gnt = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sb_stall !== 1'b0 || wr_addr !== 32'h504)
            $display("FAIL stall_release got stall %b head %h exp 0 00000504", sb_stall, wr_addr);
        else n_pass++;
        tick();
        drive_store(32'h5F4, 32'hC_EEEE);
        @(negedge clk);
        n_checks++;
        if (sb_stall !== 1'b1) $display("FAIL stall_refull got %b exp 1", sb_stall);
        else n_pass++;
        drive_load(32'h5F0);
        @(negedge clk);
        n_checks++;
        if (fwd_hit !== 1'b1 || fwd_data !== 32'hC_FFFF)
            $display("FAIL stall_pushed_fwd got hit %b data %h exp 1 000cffff", fwd_hit, fwd_data);
        else n_pass++;
        tick();
        drain();
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        issued.delete();
        written.delete();
        wr_gnt = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k < 10) begin
                d = $urandom;
                drive_store(32'h600 + 32'(4 * k), d);
                issued.push_back(ent_t'({30'(32'h180 + 32'(k)), d}));
            end else begin
                drive_idle();
            end
            @(negedge clk);
            ob = observed(); ex = expected(); n_checks++;
            if (ob !== ex || sb_stall !== 1'b0) $display("FAIL wrap c%0d got %h exp %h", k, ob, ex);
            else n_pass++;
            if (wr_req && wr_gnt) written.push_back(ent_t'({wr_addr[31:2], wr_data}));
            tick();
        end
        n_checks++;
        if (written.size() != issued.size())
            $display("FAIL wrap_count got %0d writes exp %0d", written.size(), issued.size());
        else n_pass++;
        for (int k = 0; k < issued.size() && k < written.size(); k++) begin
            n_checks++;
            if (written[k] !== issued[k])
                $display("FAIL wrap_order w%0d got %h exp %h", k, written[k], issued[k]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int op;
        for (int c = 0; c < 400; c++) begin
            op     = $urandom_range(0, 3);
            wr_gnt = ($urandom_range(0, 2) != 0);
            case (op)
                0:       drive_idle();
                1, 2:    drive_store(32'h300 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)), $urandom);
                default: drive_load(32'h300 + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3)));
            endcase
            @(negedge clk);
            ob = observed(); ex = expected(); n_checks++;
            if (ob !== ex) $display("FAIL random c%0d got %h exp %h", c, ob, ex);
            else n_pass++;
            tick();
        end
        drain();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_single_store();
        test_forward();
        test_load_priority();
        test_full_stall();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tl_store_buffer_ctrl.md
# tl_store_buffer_ctrl

Store buffer and cache write-port scheduler for the TL (tag lookup) stage. Stores leaving the EXE/TL latch are queued in a small FIFO rather than written to the data cache immediately. Queued stores drain to the cache write port whenever TL load traffic allows. Loads in TL are checked against the queue and forwarded the youngest matching store data, which keeps them coherent with pending stores.

## Interface
- DEPTH, 4, number of store entries; power of two, ≥ 2
- clk_i  in  1  clock; all state updates on rising edge
- rsn_i  in  1  reset, asynchronous, active-low
- tl_valid_i  in  1  TL stage holds a valid instruction this cycle
- tl_is_store_i  in  1  TL instruction is a word store
- tl_is_load_i  in  1  TL instruction is a word load
- tl_cache_addr_i  in  32  TL memory address; bits [1:0] ignored (word granularity)
- tl_store_data_i  in  32  store data for the TL store
- sb_stall_o  out  1  holds EXE/TL latch and earlier stages; TL store cannot be accepted
- ld_fwd_hit_o  out  1  TL load word-address matches a queued store
- ld_fwd_data_o  out  32  data of the youngest matching entry; 0 when no hit
- cache_wr_req_o  out  1  drain request to data-cache write port
- cache_wr_addr_o  out  32  head entry address, bits [1:0] forced to 0
- cache_wr_data_o  out  32  head entry data
- cache_wr_gnt_i  in  1  cache accepts the write this cycle
- sb_empty_o  out  1  no queued stores (used for fences / drain-before-halt)

## Operation
- Storage: DEPTH entries {addr[31:2], data[31:0]}. Head pointer, tail pointer and count register. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Push: tl_valid_i & tl_is_store_i & (count < DEPTH). The entry is written at the tail and the tail increments.
- Stall: sb_stall_o = tl_valid_i & tl_is_store_i & (count == DEPTH). The stall is combinational. A pop in the same cycle does not clear it; the store is accepted the following cycle.
- Drain arbitration: cache_wr_req_o = (count != 0) & (~(tl_valid_i & tl_is_load_i) | (count == DEPTH)).
  - Loads in TL have priority over the write port.
  - A full buffer takes priority over loads (anti-starvation).
- Pop: cache_wr_req_o & cache_wr_gnt_i. The head increments. cache_wr_addr_o and cache_wr_data_o always show the head entry and must stay stable while req is held without gnt.
- Push and pop in the same cycle: both take effect and count is unchanged.
- Count update: +1 on push only, −1 on pop only.
- Forwarding: a TL load compares addr[31:2] against all valid entries, i.e. the count entries starting at head.
  - Hit selects the youngest match, closest to the tail.
  - Multiple stores to the same word are legal, and each occupies its own entry.
  - Forwarding is combinational. It excludes a store being pushed in the same cycle, which is impossible because TL holds one instruction.
  - An entry popped in the current cycle still forwards.
- gnt without req is ignored.
- sb_empty_o = (count == 0).

## Timing
- Reset (rsn_i low, asynchronous):
  - count = 0, head = 0, tail = 0, entry contents don't-care.
  - Outputs: sb_stall_o 0, ld_fwd_hit_o 0, ld_fwd_data_o 0, cache_wr_req_o 0, cache_wr_addr_o 0, cache_wr_data_o 0, sb_empty_o 1.
  - Reset mid-drain discards all queued stores.
- Store in TL at cycle N into an empty buffer:
  - Entry visible from N+1 to forwarding and to cache_wr_req_o.
  - sb_empty_o falls at N+1.
- Minimum store-to-cache latency is 1 cycle after push; one pop per cycle maximum.
- A store stalled at cycle N because the buffer is full is pushed at the first cycle where count < DEPTH. That is at earliest N+1, once a pop occurs at N.
- Wrap-around: after DEPTH pushes the tail returns to 0. The FIFO order must be preserved across the wrap.

## Test plan
- Reset: hold rsn_i low mid-run with 2 entries queued → all outputs at reset values immediately. After release, sb_empty_o = 1 and no cache_wr_req_o.
- Single store, gnt always 1: store addr 0x100 data 0xDEADBEEF at cycle N → cache_wr_req_o at N+1 with addr 0x100, data 0xDEADBEEF, popped at N+1, sb_empty_o = 1 at N+2.
- Forwarding youngest: stores 0x200←0x11, 0x204←0x22, 0x200←0x33 with gnt = 0, then load 0x202 → ld_fwd_hit_o = 1, ld_fwd_data_o = 0x33. A load to 0x208 gives hit 0, data 0.
- Load priority and full override: 2 entries queued, continuous TL loads → no cache_wr_req_o. Fill to DEPTH = 4 → cache_wr_req_o asserts despite the loads.
- Full stall: 4 entries, gnt = 0, store in TL → sb_stall_o = 1 each cycle. Assert gnt for one cycle → pop at that cycle, stall drops and the store is pushed the next cycle, count back to 4.
- Wrap and simultaneous push/pop: 10 stores with gnt = 1 every cycle → cache writes in exact issue order, count never exceeds 1, pointers wrap twice without data loss.
